// File: rtl/output_argmax_pkg.sv
// Shared digit-recognition types: FSM state encoding and default
// final-layer geometry used by output_argmax and digitRecog.
package output_argmax_pkg;

   localparam int ARGMAX_NUM_INPUTS = 10;
   localparam int ARGMAX_DATA_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } argmax_state_e;

endpackage

// File: rtl/output_argmax.sv
// Sequential argmax over the final-layer neuron outputs.
// One element compared per cycle; result raised as a level interrupt.
module output_argmax
   import output_argmax_pkg::*;
#(
   parameter int NUM_INPUTS = ARGMAX_NUM_INPUTS,
   parameter int DATA_WIDTH = ARGMAX_DATA_WIDTH
) (
   input  logic                             s_axi_aclk,
   input  logic                             s_axi_aresetn,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
   input  logic                             in_valid,
   input  logic                             intr_clr,
   output logic [31:0]                      out_digit,
   output logic [DATA_WIDTH-1:0]            out_max,
   output logic                             intr,
   output logic                             busy,
   output logic                             overrun
);

   localparam int CW = $clog2(NUM_INPUTS) + 1;
   localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam logic [CW-1:0] CNT_END = CW'(NUM_INPUTS);

   argmax_state_e                r_state;
   logic signed [DATA_WIDTH-1:0] r_data [NUM_INPUTS];
   logic signed [DATA_WIDTH-1:0] r_max;
   logic signed [DATA_WIDTH-1:0] r_out_max;
   logic [IW-1:0]                r_idx;
   logic [IW-1:0]                r_out_idx;
   logic [CW-1:0]                r_cnt;
   logic                         r_intr;
   logic                         r_busy;
   logic                         r_overrun;

   logic signed [DATA_WIDTH-1:0] w_elem;
   logic                         w_gt;

   always_comb begin
      w_elem = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (r_cnt == CW'(i)) w_elem = r_data[i];
      end
   end

   // strict compare keeps the earliest index on ties
   assign w_gt = (w_elem > r_max);

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_state   <= ST_IDLE;
         r_max     <= '0;
         r_out_max <= '0;
         r_idx     <= '0;
         r_out_idx <= '0;
         r_cnt     <= '0;
         r_intr    <= 1'b0;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
         for (int i = 0; i < NUM_INPUTS; i++) r_data[i] <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (r_state == ST_DONE && intr_clr) r_overrun <= 1'b0;
               if (in_valid) begin
                  for (int i = 0; i < NUM_INPUTS; i++)
                     r_data[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
                  r_max   <= in_data[DATA_WIDTH-1:0];
                  r_idx   <= '0;
                  r_cnt   <= CW'(1);
                  r_intr  <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= ST_SCAN;
               end else if (r_state == ST_DONE && intr_clr) begin
                  r_intr  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            ST_SCAN: begin
               if (in_valid) r_overrun <= 1'b1;
               if (r_cnt == CNT_END) begin
                  r_out_idx <= r_idx;
                  r_out_max <= r_max;
                  r_intr    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= ST_DONE;
               end else begin
                  if (w_gt) begin
                     r_max <= w_elem;
                     r_idx <= r_cnt[IW-1:0];
                  end
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign out_digit = 32'(r_out_idx);
   assign out_max   = r_out_max;
   assign intr      = r_intr;
   assign busy      = r_busy;
   assign overrun   = r_overrun;

endmodule
